// File: rtl/reg_pkg.sv
// Shared definitions for the register_8 holding-stage slice.
package reg_pkg;

  // Native word width of the datapath holding stage.
  localparam int DEFAULT_WIDTH = 8;

  // Convenience type for a default-width datapath word.
  typedef logic [DEFAULT_WIDTH-1:0] word8_t;

endpackage : reg_pkg

// File: rtl/register_8_dff_bit.sv
// Single-bit storage element with a synchronous active-low reset.
// RST_BIT selects the value this bit takes while reset is held low.
module dff_bit
  import reg_pkg::*;
#(
  parameter logic RST_BIT = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic r_q;

  // Capture i_d on every rising edge; reset low overrides the data input.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_q <= RST_BIT;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule : dff_bit

// File: rtl/register_8.sv
// Parallel-load word register: one-cycle holding stage with a synchronous,
// active-low reset. Built from WIDTH independent single-bit flops so each
// bit carries its own reset value taken from RESET_VALUE.
module register_8
  import reg_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_word,
  output logic [WIDTH-1:0] out_word
);

  // Per-bit flop outputs; out_word is driven purely from these registers.
  logic [WIDTH-1:0] w_q;

  // A zero or negative width cannot hold a word.
  if (WIDTH < 1) begin : g_bad_width
    $error("register_8: WIDTH must be >= 1");
  end

  // One flop per bit, all sharing clk and reset so every bit updates together.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    dff_bit #(
      .RST_BIT (RESET_VALUE[gi])
    ) u_dff (
      .i_clk   (clk),
      .i_reset (reset),
      .i_d     (in_word[gi]),
      .o_q     (w_q[gi])
    );
  end

  assign out_word = w_q;

`ifndef SYNTHESIS
  // Becomes 1 after the first edge so $past() only looks at real history.
  logic r_past_vld;

  // Track whether at least one clock edge has been seen.
  always_ff @(posedge clk) begin
    r_past_vld <= 1'b1;
  end

  a_reset_loads_value: assert property (@(posedge clk)
    (r_past_vld === 1'b1) && !$past(reset) |-> out_word == RESET_VALUE)
    else $error("register_8: out_word not RESET_VALUE after reset edge");

  a_load_follows_input: assert property (@(posedge clk)
    (r_past_vld === 1'b1) && $past(reset) |-> out_word == $past(in_word))
    else $error("register_8: out_word does not match previous in_word");
`endif

endmodule : register_8

// File: tb/tb_register_8.sv
// Self-checking bench for register_8: directed scenarios followed by
// randomized traffic, all compared against a behavioural expectation.
module tb_register_8;
  import reg_pkg::*;

  logic   clk = 1'b0;
  logic   reset;
  word8_t in_word;
  word8_t out_word;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural expectation: the word the register should be showing now.
  word8_t expected;

  register_8 #(
    .WIDTH       (8),
    .RESET_VALUE (8'h00)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_word  (in_word),
    .out_word (out_word)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input word8_t obs, input word8_t exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: out_word=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle worth of inputs, let one rising edge pass, update the
  // expectation from the register rules, then check at the falling edge.
  task automatic step(input logic rst_n, input word8_t w, input string tag);
    reset   = rst_n;
    in_word = w;
    @(posedge clk);
    expected = rst_n ? w : 8'h00;
    @(negedge clk);
    check_eq(tag, out_word, expected);
  endtask

  initial begin
    word8_t pat [4];
    word8_t w;
    logic   r;

    pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'hAA; pat[3] = 8'h55;

    // Reset with all-ones on the input: reset must win.
    reset   = 1'b0;
    in_word = 8'hFF;
    step(1'b0, 8'hFF, "reset_ff");

    // Plain loads, one per cycle.
    step(1'b1, 8'h01, "load_01");
    step(1'b1, 8'h02, "load_02");
    step(1'b1, 8'hFF, "load_ff");
    step(1'b1, 8'hAF, "load_af");

    // Reset asserted between edges has no effect until the next edge.
    reset   = 1'b0;
    in_word = 8'hFF;
    #2;
    check_eq("reset_between_edges", out_word, 8'hAF);
    step(1'b0, 8'hFF, "midrun_reset");
    step(1'b0, 8'h3C, "reset_held_1");
    step(1'b0, 8'hFF, "reset_held_2");

    // Release: the first edge loads normally.
    step(1'b1, 8'h02, "recovery");

    // Input changes mid-cycle must not reach the output before the edge.
    reset   = 1'b1;
    in_word = 8'h55;
    #2;
    check_eq("hold_55", out_word, 8'h02);
    in_word = 8'hAA;
    #1;
    check_eq("hold_aa", out_word, 8'h02);
    @(posedge clk);
    expected = 8'hAA;
    @(negedge clk);
    check_eq("hold_capture", out_word, expected);

    // Fixed patterns and a walking one.
    foreach (pat[i]) step(1'b1, pat[i], "pattern");
    for (int i = 0; i < 8; i++) begin
      w = 8'h00;
      w[i] = 1'b1;
      step(1'b1, w, "walk1");
    end
    for (int i = 0; i < 8; i++) begin
      w = 8'hFF;
      w[i] = 1'b0;
      step(1'b1, w, "walk0");
    end

    // Randomized traffic with occasional reset pulses.
    for (int i = 0; i < 200; i++) begin
      r = ($urandom_range(0, 9) != 0);
      w = word8_t'($urandom);
      step(r, w, r ? "rand_load" : "rand_reset");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard bound on total run time.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "timeout");
  end

endmodule : tb_register_8
